memory_unit_mp: RTL and testbench

Parametrised multi-port successor to the single-client memory unit. It arbitrates round-robin among NUM_PORTS clients, such as the traversal engine, the execute unit and the loader, onto one synchronous cell RAM. It provides read, write and allocate operations, plus a new RELEASE operation that returns cells to a LIFO free stack; allocation reuses released cells before advancing the bump pointer.

---
 rtl/memory_unit_mp_pkg.sv | 14 +
 rtl/memory_unit_mp_ram.sv | 19 +
 rtl/memory_unit_mp.sv | 131 +++++++++++++
 tb/tb_memory_unit_mp.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_unit_mp_pkg.sv
// memory_unit_mp_pkg: shared function encodings, FSM states and default widths
package memory_unit_mp_pkg;
    localparam int DATA_WIDTH_DEF = 68;
    localparam int ADDR_WIDTH_DEF = 10;
    localparam int NUM_PORTS_DEF  = 3;
    localparam int FREE_DEPTH_DEF = 16;
    typedef enum logic [1:0] {
        GET_CONTENTS = 2'b00,
        SET_CONTENTS = 2'b01,
        GET_FREE     = 2'b10,
        RELEASE      = 2'b11
    } func_e;
    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_e;
endpackage

// File: rtl/memory_unit_mp_ram.sv
// memory_unit_mp_ram: single-port synchronous cell RAM, one-cycle read latency, no reset
import memory_unit_mp_pkg::*;
module memory_unit_mp_ram #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
    // write-first is irrelevant here: reads and writes never share a cycle
    always_ff @(posedge clk) begin
        if (we) ram[addr] <= wdata;
        rdata <= ram[addr];
    end
endmodule

// File: rtl/memory_unit_mp.sv
// memory_unit_mp: round-robin multi-client cell memory with bump allocator and LIFO free stack
import memory_unit_mp_pkg::*;
module memory_unit_mp #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_PORTS  = NUM_PORTS_DEF,
    parameter int FREE_DEPTH = FREE_DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [2*NUM_PORTS-1:0]          req_func,
    input  logic [ADDR_WIDTH*NUM_PORTS-1:0] req_addr,
    input  logic [DATA_WIDTH*NUM_PORTS-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_data,
    output logic [ADDR_WIDTH-1:0]           resp_addr,
    output logic                            resp_err,
    output logic                            is_ready,
    output logic [ADDR_WIDTH:0]             next_free,
    output logic [$clog2(FREE_DEPTH):0]     free_count
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int SW = $clog2(FREE_DEPTH);
    state_e                state;
    func_e                 func;
    logic [PW-1:0]         ptr, port, gnt, idx;
    logic                  found, rel_bad;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata, rdata;
    logic [ADDR_WIDTH-1:0] stack [FREE_DEPTH];
    logic [SW-1:0]         top;
    logic [NUM_PORTS-1:0]  port_oh;

    memory_unit_mp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk  (clk),
        .we   (state == EXEC && func == SET_CONTENTS),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata)
    );

    // round-robin search starting at the priority pointer
    always_comb begin
        found = 1'b0;
        gnt = '0;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = PW'((int'(ptr) + i) % NUM_PORTS);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt = idx;
            end
        end
    end

    assign req_ready = (!rst && state == IDLE && found) ? NUM_PORTS'(1) << gnt : '0;
    assign port_oh   = NUM_PORTS'(1) << port;
    assign top       = free_count[SW-1:0] - SW'(1);
    assign rel_bad   = ({1'b0, addr} >= next_free) || free_count[SW];
    assign is_ready  = state == IDLE;

    // free-stack storage holds no reset; only occupancy matters
    always_ff @(posedge clk) begin
        if (state == EXEC && func == RELEASE && !rel_bad) stack[free_count[SW-1:0]] <= addr;
    end

    // request FSM: arbitrate, execute, optional RAM wait, respond
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            port       <= '0;
            func       <= GET_CONTENTS;
            addr       <= '0;
            wdata      <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_addr  <= '0;
            resp_err   <= 1'b0;
            next_free  <= '0;
            free_count <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state <= EXEC;
                    port  <= gnt;
                    ptr   <= (gnt == PW'(NUM_PORTS - 1)) ? '0 : gnt + PW'(1);
                    func  <= func_e'(req_func[2*gnt +: 2]);
                    addr  <= req_addr[ADDR_WIDTH*gnt +: ADDR_WIDTH];
                    wdata <= req_wdata[DATA_WIDTH*gnt +: DATA_WIDTH];
                end
                EXEC: begin
                    state      <= (func == GET_CONTENTS) ? WAIT : RESP;
                    resp_valid <= (func == GET_CONTENTS) ? '0 : port_oh;
                    resp_addr  <= addr;
                    if (func == GET_FREE) begin
                        if (free_count != '0) begin
                            resp_addr  <= stack[top];
                            free_count <= free_count - (SW+1)'(1);
                        end else if (!next_free[ADDR_WIDTH]) begin
                            resp_addr <= next_free[ADDR_WIDTH-1:0];
                            next_free <= next_free + (ADDR_WIDTH+1)'(1);
                        end else begin
                            resp_addr <= '0;
                            resp_err  <= 1'b1;
                        end
                    end
                    if (func == RELEASE) begin
                        resp_err <= rel_bad;
                        if (!rel_bad) free_count <= free_count + (SW+1)'(1);
                    end
                end
                WAIT: begin
                    state      <= RESP;
                    resp_data  <= rdata;
                    resp_valid <= port_oh;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= '0;
                    resp_data  <= '0;
                    resp_addr  <= '0;
                    resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_unit_mp.sv
// tb_memory_unit_mp: directed scoreboard bench for memory_unit_mp
module tb_memory_unit_mp;
    localparam int NP = 3;
    localparam int AW = 10;
    localparam int DW = 68;
    localparam logic [1:0] F_GET = 2'b00, F_SET = 2'b01, F_FREE = 2'b10, F_REL = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NP-1:0]    rv = '0;
    logic [2*NP-1:0]  rf = '0;
    logic [AW*NP-1:0] ra = '0;
    logic [DW*NP-1:0] rw = '0;
    logic [NP-1:0]    rr, rsv;
    logic [DW-1:0]    rd;
    logic [AW-1:0]    rsa;
    logic             re, ir;
    logic [AW:0]      nf;
    logic [4:0]       fc;

    logic [1:0]   rv2 = '0;
    logic [3:0]   rf2 = '0;
    logic [5:0]   ra2 = '0;
    logic [135:0] rw2 = '0;
    logic [1:0]   rr2, rsv2;
    logic [DW-1:0] rd2;
    logic [2:0]   rsa2;
    logic         re2, ir2;
    logic [3:0]   nf2;
    logic [2:0]   fc2;

    memory_unit_mp dut (
        .clk(clk), .rst(rst), .req_valid(rv), .req_func(rf), .req_addr(ra), .req_wdata(rw),
        .req_ready(rr), .resp_valid(rsv), .resp_data(rd), .resp_addr(rsa), .resp_err(re),
        .is_ready(ir), .next_free(nf), .free_count(fc)
    );

    memory_unit_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .NUM_PORTS(2), .FREE_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .req_valid(rv2), .req_func(rf2), .req_addr(ra2), .req_wdata(rw2),
        .req_ready(rr2), .resp_valid(rsv2), .resp_data(rd2), .resp_addr(rsa2), .resp_err(re2),
        .is_ready(ir2), .next_free(nf2), .free_count(fc2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          err;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int acc_cyc[NP];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && rsv != '0) begin
            if (sb.size() == 0) chk("unexpected_resp", DW'(rsv), '0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_valid", DW'(rsv), DW'(NP'(1) << e.port));
                chk("resp_data", rd, e.data);
                chk("resp_addr", DW'(rsa), DW'(e.addr));
                chk("resp_err", DW'(re), DW'(e.err));
                chk("latency", DW'(cyc - acc_cyc[e.port]), DW'(e.lat));
            end
        end
    end

    task automatic step();
        logic [NP-1:0] g;
        #1 g = rr;
        for (int p = 0; p < NP; p++) if (g[p]) acc_cyc[p] = cyc;
        @(posedge clk);
        #1 rv = rv & ~g;
    endtask

    task automatic drive(input int p, input logic [1:0] f, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] ed, input logic [AW-1:0] ea, input logic ee);
        exp_t e;
        rv[p] = 1'b1;
        rf[2*p +: 2] = f;
        ra[AW*p +: AW] = a;
        rw[DW*p +: DW] = d;
        e.port = p;
        e.data = ed;
        e.addr = ea;
        e.err = ee;
        e.lat = (f == F_GET) ? 3 : 2;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rv != '0) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("drain_timeout", DW'(sb.size()), '0);
    endtask

    task automatic op(input int p, input logic [1:0] f, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] ed, input logic [AW-1:0] ea, input logic ee);
        @(negedge clk);
        drive(p, f, a, d, ed, ea, ee);
        drain();
    endtask

    task automatic req2(input logic [1:0] f, input logic [2:0] a, input logic [2:0] ea, input logic ee);
        int n;
        @(negedge clk);
        rv2[0] = 1'b1;
        rf2[1:0] = f;
        ra2[2:0] = a;
        #1 n = 0;
        while (!rr2[0] && n < 20) begin
            @(negedge clk);
            #1 n++;
        end
        if (n >= 20) chk("req2_ready_timeout", DW'(rr2), 1);
        @(posedge clk);
        #1 rv2[0] = 1'b0;
        n = 0;
        while (!rsv2[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("req2_resp_timeout", DW'(rsv2), 1);
        chk("w3_resp_addr", DW'(rsa2), DW'(ea));
        chk("w3_resp_err", DW'(re2), DW'(ee));
    endtask

    initial begin
        dut.u_ram.ram[5] = 68'h1234;
        rv = '1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", DW'(rr), '0);
        chk("rst_is_ready", DW'(ir), 1);
        chk("rst_resp_valid", DW'(rsv), '0);
        chk("rst_resp_data", rd, '0);
        chk("rst_resp_addr", DW'(rsa), '0);
        chk("rst_resp_err", DW'(re), '0);
        chk("rst_next_free", DW'(nf), '0);
        chk("rst_free_count", DW'(fc), '0);
        rv = '0;
        @(negedge clk);
        rst = 1'b0;
        op(0, F_GET, 5, 0, 68'h1234, 5, 0);
        op(1, F_FREE, 0, 0, 0, 0, 0);
        op(1, F_FREE, 0, 0, 0, 1, 0);
        chk("next_free_2", DW'(nf), 2);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        drive(0, F_FREE, 0, 0, 0, 0, 0);
        drive(1, F_FREE, 0, 0, 0, 1, 0);
        drive(2, F_FREE, 0, 0, 0, 2, 0);
        drain();
        @(negedge clk);
        drive(0, F_FREE, 0, 0, 0, 3, 0);
        drive(1, F_FREE, 0, 0, 0, 4, 0);
        drive(2, F_FREE, 0, 0, 0, 5, 0);
        drain();
        chk("next_free_6", DW'(nf), 6);
        op(1, F_FREE, 0, 0, 0, 6, 0);
        @(negedge clk);
        drive(2, F_FREE, 0, 0, 0, 7, 0);
        drive(0, F_FREE, 0, 0, 0, 8, 0);
        drive(1, F_FREE, 0, 0, 0, 9, 0);
        drain();
        chk("next_free_10", DW'(nf), 10);
        op(2, F_SET, 3, 68'hDEADBEEF, 0, 3, 0);
        op(0, F_REL, 3, 0, 0, 3, 0);
        chk("free_count_1", DW'(fc), 1);
        op(1, F_FREE, 0, 0, 0, 3, 0);
        chk("free_count_pop", DW'(fc), 0);
        chk("next_free_kept", DW'(nf), 10);
        op(2, F_GET, 3, 0, 68'hDEADBEEF, 3, 0);
        op(0, F_REL, 900, 0, 0, 900, 1);
        op(1, F_REL, 10, 0, 0, 10, 1);
        chk("free_count_bad_rel", DW'(fc), 0);
        for (int i = 10; i < 16; i++) op(0, F_FREE, 0, 0, 0, AW'(i), 0);
        chk("next_free_16", DW'(nf), 16);
        op(1, F_REL, 15, 0, 0, 15, 0);
        for (int i = 0; i < 15; i++) op(2, F_REL, AW'(i), 0, 0, AW'(i), 0);
        chk("free_count_full", DW'(fc), 16);
        op(0, F_REL, 0, 0, 0, 0, 1);
        chk("free_count_overflow", DW'(fc), 16);
        op(1, F_FREE, 0, 0, 0, 14, 0);
        chk("free_count_15", DW'(fc), 15);
        @(negedge clk);
        rv[0] = 1'b1;
        rf[1:0] = F_SET;
        ra[AW-1:0] = 5;
        rw[DW-1:0] = 68'hBAD;
        step();
        rst = 1'b1;
        #1;
        chk("mid_req_ready", DW'(rr), '0);
        chk("mid_resp_valid", DW'(rsv), '0);
        chk("mid_is_ready", DW'(ir), 1);
        chk("mid_next_free", DW'(nf), '0);
        chk("mid_free_count", DW'(fc), '0);
        chk("mid_resp_addr", DW'(rsa), '0);
        @(negedge clk) rst = 1'b0;
        repeat (4) step();
        op(0, F_GET, 5, 0, 68'h1234, 5, 0);
        op(1, F_GET, 3, 0, 68'hDEADBEEF, 3, 0);
        for (int i = 0; i < 9; i++) req2(F_FREE, 0, (i < 8) ? 3'(i) : 3'd0, i == 8);
        chk("w3_next_free", DW'(nf2), 8);
        req2(F_REL, 3, 3, 0);
        chk("w3_free_count_1", DW'(fc2), 1);
        req2(F_FREE, 0, 3, 0);
        chk("w3_free_count_0", DW'(fc2), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
